// File: rtl/light_sensor_filter_bank.sv
// Multi-channel light-sensor debouncer with a run-time threshold and rise/fall strobes.
// Optional per-channel glitch counters are enabled by defining LIGHT_SENSOR_GLITCH_COUNT_EN.
module light_sensor_filter_bank #(
  parameter int CHANNELS        = 3,
  parameter int COUNT_W         = 17,
  parameter int DEFAULT_REPEATS = 25000,
  parameter int GLITCH_W        = 8,
  localparam int SEL_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sensor_raw,
  input  logic                thr_load,
  input  logic [COUNT_W-1:0]  thr_value,
`ifdef LIGHT_SENSOR_GLITCH_COUNT_EN
  input  logic [SEL_W-1:0]    glitch_sel,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_count,
`endif
  output logic [COUNT_W-1:0]  threshold,
  output logic [CHANNELS-1:0] sensor_filtered,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] busy
);

  // Last run count before acceptance; a zero threshold behaves as one.
  function automatic logic [COUNT_W-1:0] lastCount(input logic [COUNT_W-1:0] thr);
    return (thr == '0) ? '0 : thr - COUNT_W'(1);
  endfunction

  function automatic logic [GLITCH_W-1:0] satInc(input logic [GLITCH_W-1:0] val);
    return (val == '1) ? val : val + GLITCH_W'(1);
  endfunction

  logic [CHANNELS-1:0] sync_p0;
  logic [CHANNELS-1:0] sync_p1;
  logic [COUNT_W-1:0]  runCnt [CHANNELS];
  logic [COUNT_W-1:0]  runLast;
  logic [CHANNELS-1:0] mismatch;
  logic [CHANNELS-1:0] accept;

  always_comb begin
    runLast  = lastCount(threshold);
    mismatch = '0;
    accept   = '0;
    busy     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mismatch[i] = sync_p1[i] ^ sensor_filtered[i];
      accept[i]   = mismatch[i] && (runCnt[i] >= runLast) && !thr_load;
      busy[i]     = (runCnt[i] != '0);
    end
  end

  // Stage p0/p1: two-flop synchronizer; then run counting against the accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0         <= '0;
      sync_p1         <= '0;
      threshold       <= COUNT_W'(DEFAULT_REPEATS);
      sensor_filtered <= '0;
      rise_pulse      <= '0;
      fall_pulse      <= '0;
      for (int i = 0; i < CHANNELS; i++) runCnt[i] <= '0;
    end else begin
      sync_p0 <= sensor_raw;
      sync_p1 <= sync_p0;
      if (thr_load) threshold <= thr_value;
      for (int i = 0; i < CHANNELS; i++) begin
        rise_pulse[i] <= accept[i] && sync_p1[i];
        fall_pulse[i] <= accept[i] && !sync_p1[i];
        if (accept[i]) sensor_filtered[i] <= sync_p1[i];
        // A threshold reload restarts every pending run, even one about to be accepted.
        if (thr_load || !mismatch[i] || accept[i]) runCnt[i] <= '0;
        else runCnt[i] <= runCnt[i] + COUNT_W'(1);
      end
    end
  end

`ifdef LIGHT_SENSOR_GLITCH_COUNT_EN
  logic [GLITCH_W-1:0] glitchCnt [CHANNELS];

  // A rejected flicker is a pending run that ends with the line back at the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) glitchCnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (glitch_clr && (glitch_sel == SEL_W'(i))) glitchCnt[i] <= '0;
        else if ((runCnt[i] != '0) && !mismatch[i]) glitchCnt[i] <= satInc(glitchCnt[i]);
      end
    end
  end

  always_comb begin
    glitch_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (glitch_sel == SEL_W'(i)) glitch_count = glitchCnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_light_sensor_filter_bank.sv
// Self-checking bench for light_sensor_filter_bank: directed scenarios plus randomized
// traffic compared against a behavioural run-length model of each channel.
module tb_light_sensor_filter_bank;
  localparam int CH  = 3;
  localparam int CW  = 17;
  localparam int DEF = 4;
  localparam int GW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] sensor_raw = '0;
  logic          thr_load = 1'b0;
  logic [CW-1:0] thr_value = '0;
  logic [CW-1:0] threshold;
  logic [CH-1:0] sensor_filtered;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;
  logic [CH-1:0] busy;
`ifdef LIGHT_SENSOR_GLITCH_COUNT_EN
  logic [1:0]    glitch_sel = 2'd1;
  logic          glitch_clr = 1'b0;
  logic [GW-1:0] glitch_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  light_sensor_filter_bank #(
    .CHANNELS(CH), .COUNT_W(CW), .DEFAULT_REPEATS(DEF), .GLITCH_W(GW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sensor_raw(sensor_raw),
    .thr_load(thr_load),
    .thr_value(thr_value),
`ifdef LIGHT_SENSOR_GLITCH_COUNT_EN
    .glitch_sel(glitch_sel),
    .glitch_clr(glitch_clr),
    .glitch_count(glitch_count),
`endif
    .threshold(threshold),
    .sensor_filtered(sensor_filtered),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy(busy)
  );

  // Reference model: a change is accepted once the synchronized line has disagreed with
  // the accepted level on eff_thr consecutive samples; the line reaches the decision
  // point two samples after it is captured from the pin.
  int mPin1 [CH];
  int mPin2 [CH];
  int mLevel [CH];
  int mStreak [CH];
  int mRise [CH];
  int mFall [CH];
  int mGlitch [CH];
  int mThr = DEF;

  always @(posedge clk) begin
    int eff;
    eff = (mThr < 1) ? 1 : mThr;
    for (int c = 0; c < CH; c++) begin
      mRise[c] = 0;
      mFall[c] = 0;
      if (reset) begin
        mPin1[c] = 0; mPin2[c] = 0; mLevel[c] = 0; mStreak[c] = 0; mGlitch[c] = 0;
      end else begin
        if (mPin2[c] == mLevel[c]) begin
          if (mStreak[c] > 0 && mGlitch[c] < 255) mGlitch[c]++;
          mStreak[c] = 0;
        end else if (thr_load) begin
          mStreak[c] = 0;
        end else if (mStreak[c] + 1 >= eff) begin
          mLevel[c] = mPin2[c];
          if (mLevel[c] == 1) mRise[c] = 1; else mFall[c] = 1;
          mStreak[c] = 0;
        end else begin
          mStreak[c]++;
        end
`ifdef LIGHT_SENSOR_GLITCH_COUNT_EN
        if (glitch_clr && int'(glitch_sel) == c) mGlitch[c] = 0;
`endif
        mPin2[c] = mPin1[c];
        mPin1[c] = int'(sensor_raw[c]);
      end
    end
    if (reset) mThr = DEF;
    else if (thr_load) mThr = int'(thr_value);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (sensor_filtered !== 3'b000 || rise_pulse !== 3'b000 || fall_pulse !== 3'b000
          || busy !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_idle: filt=%b rise=%b fall=%b busy=%b required all 000",
                 sensor_filtered, rise_pulse, fall_pulse, busy);
      end
      vectors++;
      if (threshold !== CW'(DEF)) begin
        miscompares++;
        $display("FAIL reset_threshold: got %0d required %0d", threshold, DEF);
      end
    end
  endtask

  task automatic test_step();
    sensor_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if (sensor_filtered !== ((k >= 6) ? 3'b001 : 3'b000)) begin
        miscompares++;
        $display("FAIL step_filt@%0d: got %b required %b", k, sensor_filtered,
                 (k >= 6) ? 3'b001 : 3'b000);
      end
      vectors++;
      if (rise_pulse !== ((k == 6) ? 3'b001 : 3'b000) || fall_pulse !== 3'b000) begin
        miscompares++;
        $display("FAIL step_pulse@%0d: rise=%b fall=%b", k, rise_pulse, fall_pulse);
      end
    end
  endtask

  task automatic test_flicker();
    sensor_raw[1] = 1'b1;
    tick(); tick(); tick();
    sensor_raw[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (sensor_filtered[1] !== 1'b0 || rise_pulse[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL flicker_reject@%0d: filt1=%b rise1=%b required 0 0", k,
                 sensor_filtered[1], rise_pulse[1]);
      end
    end
`ifdef LIGHT_SENSOR_GLITCH_COUNT_EN
    glitch_sel = 2'd1;
    #1;
    vectors++;
    if (glitch_count !== GW'(1)) begin
      miscompares++;
      $display("FAIL glitch_count_ch1: got %0d required 1", glitch_count);
    end
`endif
  endtask

  task automatic test_thr_load_midrun();
    sensor_raw[2] = 1'b1;
    tick(); tick(); tick(); tick();
    vectors++;
    if (busy[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL thr_midrun_busy: got %b required 1", busy[2]);
    end
    thr_load = 1'b1;
    thr_value = '0;
    tick();
    thr_load = 1'b0;
    vectors++;
    if (threshold !== '0 || busy[2] !== 1'b0 || sensor_filtered[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL thr_load_clear: thr=%0d busy2=%b filt2=%b required 0 0 0",
               threshold, busy[2], sensor_filtered[2]);
    end
    tick();
    vectors++;
    if (sensor_filtered[2] !== 1'b1 || rise_pulse[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL thr_zero_flip: filt2=%b rise2=%b required 1 1",
               sensor_filtered[2], rise_pulse[2]);
    end
  endtask

  task automatic test_back_to_back();
    thr_load = 1'b1;
    thr_value = CW'(4);
    sensor_raw[0] = 1'b0;
    tick();
    thr_load = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    vectors++;
    if (sensor_filtered !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_setup: got %b required 100", sensor_filtered);
    end
    sensor_raw = 3'b001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if (rise_pulse !== ((k == 6) ? 3'b001 : 3'b000)
          || fall_pulse !== ((k == 6) ? 3'b100 : 3'b000)
          || sensor_filtered !== ((k >= 6) ? 3'b001 : 3'b100)) begin
        miscompares++;
        $display("FAIL b2b_same_cycle@%0d: rise=%b fall=%b filt=%b", k, rise_pulse,
                 fall_pulse, sensor_filtered);
      end
    end
  endtask

  task automatic test_reset_midrun();
    sensor_raw[1] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (busy !== 3'b010) begin
      miscompares++;
      $display("FAIL midrun_busy: got %b required 010", busy);
    end
    reset = 1'b1;
    thr_load = 1'b1;
    thr_value = CW'(7);
    tick();
    vectors++;
    if (sensor_filtered !== 3'b000 || rise_pulse !== 3'b000 || fall_pulse !== 3'b000
        || busy !== 3'b000 || threshold !== CW'(DEF)) begin
      miscompares++;
      $display("FAIL reset_midrun: filt=%b rise=%b fall=%b busy=%b thr=%0d required 0s thr=%0d",
               sensor_filtered, rise_pulse, fall_pulse, busy, threshold, DEF);
    end
    reset = 1'b0;
    thr_load = 1'b0;
    sensor_raw = '0;
    tick();
    vectors++;
    if (rise_pulse !== 3'b000 || fall_pulse !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_no_pulse: rise=%b fall=%b required 000 000", rise_pulse, fall_pulse);
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] expFilt, expRise, expFall, expBusy;
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      thr_load = ($urandom_range(0, 39) == 0);
      thr_value = CW'($urandom_range(0, 6));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) sensor_raw[c] = ~sensor_raw[c];
      end
`ifdef LIGHT_SENSOR_GLITCH_COUNT_EN
      glitch_sel = 2'($urandom_range(0, 3));
      glitch_clr = ($urandom_range(0, 19) == 0);
`endif
      tick();
      for (int c = 0; c < CH; c++) begin
        expFilt[c] = (mLevel[c] != 0);
        expRise[c] = (mRise[c] != 0);
        expFall[c] = (mFall[c] != 0);
        expBusy[c] = (mStreak[c] != 0);
      end
      vectors++;
      if (sensor_filtered !== expFilt) begin
        miscompares++;
        $display("FAIL rand_filt@%0d: got %b required %b", n, sensor_filtered, expFilt);
      end
      vectors++;
      if (rise_pulse !== expRise || fall_pulse !== expFall) begin
        miscompares++;
        $display("FAIL rand_pulse@%0d: rise=%b fall=%b required %b %b", n, rise_pulse,
                 fall_pulse, expRise, expFall);
      end
      vectors++;
      if (busy !== expBusy) begin
        miscompares++;
        $display("FAIL rand_busy@%0d: got %b required %b", n, busy, expBusy);
      end
      vectors++;
      if (threshold !== CW'(mThr)) begin
        miscompares++;
        $display("FAIL rand_thr@%0d: got %0d required %0d", n, threshold, mThr);
      end
`ifdef LIGHT_SENSOR_GLITCH_COUNT_EN
      vectors++;
      if (glitch_count !== ((int'(glitch_sel) < CH) ? GW'(mGlitch[glitch_sel]) : GW'(0))) begin
        miscompares++;
        $display("FAIL rand_glitch@%0d: sel=%0d got %0d", n, glitch_sel, glitch_count);
      end
`endif
    end
    reset = 1'b0;
    thr_load = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_step();
    test_flicker();
    test_thr_load_midrun();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
